// File: rtl/timer_display_if.sv
// Purpose: bundles the timer count input and the display/digit outputs of timer_display.
// Latency: none; this file only declares wires.
// Backpressure: none; digits_valid is a one-cycle strobe that consumers cannot stall.
// Ports: count_in (14b tenths count), seg_n/an_n (active-low LED drive),
//        digits_out (BCD M:SS.T), digits_valid (update strobe).
interface timer_display_if;
  logic [13:0] count_in;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits_out;
  logic        digits_valid;

  // master: the display block itself, which consumes the count and drives the outputs
  modport master (
    input  count_in,
    output seg_n,
    output an_n,
    output digits_out,
    output digits_valid
  );

  // slave: whoever supplies the count and watches the display/digits
  modport slave (
    output count_in,
    input  seg_n,
    input  an_n,
    input  digits_out,
    input  digits_valid
  );
endinterface

// File: rtl/timer_display.sv
// Purpose: converts a 14-bit tenths count to BCD M:SS.T by repeated subtraction and scans it onto a 4-digit 7-seg.
// Latency: 1 + (m+1) + (ts+1) + (s+1) + 1 clocks from the sample edge to the digits_out update; overflow takes 2.
// Backpressure: none; the converter free-runs and pulses digits_valid after every conversion.
// Ports: clk_in, rst_n (async active-low), bus (timer_display_if.master):
//        count_in in, seg_n/an_n out (active low), digits_out {min,tsec,sec,tenths}, digits_valid strobe.
module timer_display #(
  parameter int MAX_COUNT = 5999,
  parameter int SCAN_DIV  = 50000
) (
  input  logic            clk_in,
  input  logic            rst_n,
  timer_display_if.master bus
);

  localparam int PSC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IDLE, MIN, TSEC, SEC, DONE} state_t;

  state_t      state;
  logic [13:0] work;
  logic [3:0]  min_d, tsec_d, sec_d, tenths_d;
  logic        ovf;

  // ---------------------------------------------------------------- converter
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      work              <= '0;
      min_d             <= '0;
      tsec_d            <= '0;
      sec_d             <= '0;
      tenths_d          <= '0;
      ovf               <= 1'b0;
      bus.digits_out    <= 16'h0000;
      bus.digits_valid  <= 1'b0;
    end else begin
      bus.digits_valid <= 1'b0;
      case (state)
        IDLE: begin
          work     <= bus.count_in;
          min_d    <= '0;
          tsec_d   <= '0;
          sec_d    <= '0;
          tenths_d <= '0;
          if (bus.count_in > 14'(MAX_COUNT)) begin
            ovf   <= 1'b1;
            state <= DONE;
          end else begin
            ovf   <= 1'b0;
            state <= MIN;
          end
        end
        // Each digit stage subtracts only while work >= weight, so work never wraps.
        MIN: begin
          if (work >= 14'd600) begin
            work  <= work - 14'd600;
            min_d <= min_d + 4'd1;
          end else begin
            state <= TSEC;
          end
        end
        TSEC: begin
          if (work >= 14'd100) begin
            work   <= work - 14'd100;
            tsec_d <= tsec_d + 4'd1;
          end else begin
            state <= SEC;
          end
        end
        SEC: begin
          if (work >= 14'd10) begin
            work  <= work - 14'd10;
            sec_d <= sec_d + 4'd1;
          end else begin
            tenths_d <= work[3:0];
            state    <= DONE;
          end
        end
        DONE: begin
          bus.digits_out   <= ovf ? 16'hFFFF : {min_d, tsec_d, sec_d, tenths_d};
          bus.digits_valid <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- display scan
  logic [PSC_W-1:0] presc;
  logic [1:0]       scan_idx;
  logic [1:0]       next_idx;
  logic [3:0]       sel_digit;
  logic             dp_n;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;  // non-decimal nibble: dash
    endcase
  endfunction

  always_comb begin
    next_idx  = scan_idx + 2'd1;
    sel_digit = 4'h0;
    case (next_idx)
      2'd0: sel_digit = bus.digits_out[3:0];
      2'd1: sel_digit = bus.digits_out[7:4];
      2'd2: sel_digit = bus.digits_out[11:8];
      2'd3: sel_digit = bus.digits_out[15:12];
      default: sel_digit = 4'h0;
    endcase
    // dp separates M:SS and SS.T; suppressed while the overflow pattern is shown
    dp_n = ~(((next_idx == 2'd3) || (next_idx == 2'd1)) && (bus.digits_out != 16'hFFFF));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      scan_idx  <= 2'd0;
      bus.an_n  <= 4'b1111;
      bus.seg_n <= 8'hFF;
    end else if (presc == PSC_W'(SCAN_DIV - 1)) begin
      presc     <= '0;
      scan_idx  <= next_idx;
      bus.an_n  <= ~(4'b0001 << next_idx);
      bus.seg_n <= {dp_n, seg_code(sel_digit)};
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule
